// File: rtl/solver_dispatcher.sv
// solver_dispatcher: walks a frame pixel by pixel, launching one job per cycle
// on a round-robin choice of ready, non-busy solvers, then drains before signalling done.
module solver_dispatcher #(
    parameter int NUM_SOLVERS = 4,
    parameter int NUM_COLUMNS = 640,
    parameter int NUM_ROWS    = 480
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_SOLVERS-1:0] solver_ready,
    input  logic [NUM_SOLVERS-1:0] solver_done,
    output logic [NUM_SOLVERS-1:0] solver_start,
    output logic [9:0]             job_x,
    output logic [8:0]             job_y,
    output logic [18:0]            job_addr,
    output logic                   busy,
    output logic [5:0]             outstanding,
    output logic                   frame_done
);
    localparam int RW = NUM_SOLVERS > 1 ? $clog2(NUM_SOLVERS) : 1;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;

    state_t                 state, state_d;
    logic [NUM_SOLVERS-1:0] inflight, eligible, grant;
    logic [RW-1:0]          rr, idx, gidx;
    logic                   found, grant_valid, last_col, last_pix, frame_done_d;
    logic [9:0]             x;
    logic [8:0]             y;
    logic [18:0]            addr;

    assign eligible    = solver_ready & ~inflight;
    assign grant_valid = (state == DISPATCH) && found && !abort;
    assign grant       = grant_valid ? (NUM_SOLVERS'(1) << gidx) : '0;
    assign last_col    = x == 10'(NUM_COLUMNS - 1);
    assign last_pix    = last_col && (y == 9'(NUM_ROWS - 1));
    assign busy        = state != IDLE;
    assign outstanding = 6'($countones(inflight));

    // First eligible solver at or after rr, wrapping around the pool.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            idx = RW'((int'(rr) + k) % NUM_SOLVERS);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (start) state_d = DISPATCH;
            DISPATCH: if (grant_valid && last_pix) state_d = DRAIN;
            DRAIN:    if (inflight == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    assign frame_done_d = (state == DRAIN) && (inflight == '0) && !abort;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight     <= '0;
            rr           <= '0;
            x            <= '0;
            y            <= '0;
            addr         <= '0;
            solver_start <= '0;
            job_x        <= '0;
            job_y        <= '0;
            job_addr     <= '0;
            frame_done   <= 1'b0;
        end else begin
            solver_start <= grant;
            frame_done   <= frame_done_d;
            inflight     <= abort ? '0 : ((inflight & ~solver_done) | grant);
            if (grant_valid) begin
                job_x    <= x;
                job_y    <= y;
                job_addr <= addr;
                rr       <= (gidx == RW'(NUM_SOLVERS - 1)) ? '0 : gidx + 1'b1;
                x        <= last_col ? '0 : x + 1'b1;
                y        <= last_col ? y + 1'b1 : y;
                addr     <= addr + 1'b1;
            end else if (state == IDLE && start && !abort) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_solver_dispatcher.sv
// tb_solver_dispatcher: directed scenarios on a 3-solver 4x2 dispatcher plus a 1-solver 5x3 one.
module tb_solver_dispatcher;
    logic        clock = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic [2:0]  solver_ready = '0, solver_done = '0, solver_start;
    logic [9:0]  job_x;
    logic [8:0]  job_y;
    logic [18:0] job_addr;
    logic        busy, frame_done;
    logic [5:0]  outstanding;

    logic        start2 = 1'b0, abort2 = 1'b0;
    logic [0:0]  ready2 = '0, done2 = '0, solver_start2;
    logic [9:0]  job_x2;
    logic [8:0]  job_y2;
    logic [18:0] job_addr2;
    logic        busy2, frame_done2;
    logic [5:0]  outstanding2;

    int tests = 0, failed = 0;

    always #5 clock = ~clock;

    solver_dispatcher #(.NUM_SOLVERS(3), .NUM_COLUMNS(4), .NUM_ROWS(2)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .solver_ready(solver_ready), .solver_done(solver_done), .solver_start(solver_start),
        .job_x(job_x), .job_y(job_y), .job_addr(job_addr),
        .busy(busy), .outstanding(outstanding), .frame_done(frame_done)
    );

    solver_dispatcher #(.NUM_SOLVERS(1), .NUM_COLUMNS(5), .NUM_ROWS(3)) dut1 (
        .clock(clock), .reset(reset), .start(start2), .abort(abort2),
        .solver_ready(ready2), .solver_done(done2), .solver_start(solver_start2),
        .job_x(job_x2), .job_y(job_y2), .job_addr(job_addr2),
        .busy(busy2), .outstanding(outstanding2), .frame_done(frame_done2)
    );

    task automatic do_reset();
        start = 0; abort = 0; solver_ready = '0; solver_done = '0;
        start2 = 0; ready2 = '0; done2 = '0;
        reset = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({solver_start, job_x, job_y, job_addr, busy, outstanding, frame_done} !== '0) begin
            failed++;
            $display("FAIL reset_state: start=%b x=%0d y=%0d addr=%0d busy=%b out=%0d fd=%b, expected all zero",
                     solver_start, job_x, job_y, job_addr, busy, outstanding, frame_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [2:0] prev = '0;
        do_reset();
        solver_ready = 3'b111;
        start = 1; @(negedge clock); start = 0;
        repeat (3) begin
            @(negedge clock);
            solver_done = prev;
            prev = solver_start;
        end
        tests++;
        if (busy !== 1'b1 || job_addr !== 19'd2) begin
            failed++;
            $display("FAIL mid_frame_pre: busy=%b addr=%0d, expected busy=1 addr=2", busy, job_addr);
        end
        reset = 0;
        #1;
        tests++;
        if ({solver_start, job_x, job_y, job_addr, busy, outstanding, frame_done} !== '0) begin
            failed++;
            $display("FAIL mid_frame_reset: start=%b x=%0d y=%0d addr=%0d busy=%b out=%0d fd=%b, expected all zero",
                     solver_start, job_x, job_y, job_addr, busy, outstanding, frame_done);
        end
        solver_done = '0;
        repeat (2) @(negedge clock);
        reset = 1;
        repeat (3) @(negedge clock);
        tests++;
        if (busy !== 1'b0 || solver_start !== 3'b000 || frame_done !== 1'b0) begin
            failed++;
            $display("FAIL mid_frame_release: busy=%b start=%b fd=%b, expected 0 0 0", busy, solver_start, frame_done);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] prev = '0;
        int n = 0, fd = 0;
        do_reset();
        solver_ready = 3'b111;
        start = 1; @(negedge clock); start = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            solver_done = prev;
            prev = solver_start;
            if (frame_done) begin
                fd++;
                tests++;
                if (n != 8 || outstanding !== 6'd0) begin
                    failed++;
                    $display("FAIL rr_frame_done: starts=%0d out=%0d, expected 8 and 0", n, outstanding);
                end
            end
            if (solver_start !== 3'b000) begin
                tests++;
                if (solver_start !== 3'(1 << (n % 3)) || job_addr !== 19'(n) ||
                    job_x !== 10'(n % 4) || job_y !== 9'(n / 4)) begin
                    failed++;
                    $display("FAIL rr_start%0d: start=%b addr=%0d x=%0d y=%0d, expected start=%b addr=%0d x=%0d y=%0d",
                             n, solver_start, job_addr, job_x, job_y, 3'(1 << (n % 3)), n, n % 4, n / 4);
                end
                n++;
            end
        end
        solver_done = '0;
        tests++;
        if (n != 8 || fd != 1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL rr_totals: starts=%0d frame_done=%0d busy=%b, expected 8 1 0", n, fd, busy);
        end
    endtask

    task automatic test_single_ready();
        int n = 0;
        logic got = 0;
        do_reset();
        solver_ready = 3'b010;
        start = 1; @(negedge clock); start = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (solver_start !== 3'b000) begin
                n++;
                tests++;
                if (solver_start !== 3'b010 || job_addr !== 19'd0) begin
                    failed++;
                    $display("FAIL single_first: start=%b addr=%0d, expected 010 addr 0", solver_start, job_addr);
                end
            end
        end
        tests++;
        if (n != 1 || outstanding !== 6'd1 || busy !== 1'b1) begin
            failed++;
            $display("FAIL single_stall: starts=%0d out=%0d busy=%b, expected 1 1 1", n, outstanding, busy);
        end
        solver_done = 3'b010;
        @(negedge clock);
        solver_done = '0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clock);
            if (solver_start !== 3'b000) begin
                got = 1;
                tests++;
                if (solver_start !== 3'b010 || job_addr !== 19'd1 || job_x !== 10'd1 || job_y !== 9'd0) begin
                    failed++;
                    $display("FAIL single_second: start=%b addr=%0d x=%0d y=%0d, expected 010 addr 1 x 1 y 0",
                             solver_start, job_addr, job_x, job_y);
                end
            end
        end
        tests++;
        if (!got) begin
            failed++;
            $display("FAIL single_second_timeout: got=0, expected a grant after done");
        end
        abort = 1; @(negedge clock); abort = 0;
    endtask

    task automatic test_start_held();
        logic [2:0] prev = '0;
        int n = 0;
        logic seen_fd = 0, seen_new = 0;
        do_reset();
        solver_ready = 3'b111;
        start = 1;
        for (int c = 0; c < 40 && !seen_new; c++) begin
            @(negedge clock);
            solver_done = prev;
            prev = solver_start;
            if (frame_done && !seen_fd) begin
                seen_fd = 1;
                tests++;
                if (n != 8) begin
                    failed++;
                    $display("FAIL held_frame_done: starts=%0d, expected 8", n);
                end
            end else if (solver_start !== 3'b000) begin
                tests++;
                if (!seen_fd) begin
                    if (job_addr !== 19'(n)) begin
                        failed++;
                        $display("FAIL held_no_restart: addr=%0d, expected %0d", job_addr, n);
                    end
                    n++;
                end else begin
                    seen_new = 1;
                    if (job_addr !== 19'd0 || job_x !== 10'd0 || job_y !== 9'd0) begin
                        failed++;
                        $display("FAIL held_new_frame: addr=%0d x=%0d y=%0d, expected 0 0 0", job_addr, job_x, job_y);
                    end
                end
            end
        end
        tests++;
        if (!seen_new) begin
            failed++;
            $display("FAIL held_timeout: frame_done=%b new_frame=%b, expected both 1", seen_fd, seen_new);
        end
        start = 0; solver_done = '0;
        abort = 1; @(negedge clock); abort = 0;
    endtask

    task automatic test_abort();
        logic [2:0] prev = '0, last = '0;
        int fd = 0;
        logic hit = 0;
        do_reset();
        solver_ready = 3'b111;
        start = 1; @(negedge clock); start = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clock);
            solver_done = prev;
            prev = solver_start;
            if (solver_start !== 3'b000 && job_addr == 19'd5) hit = 1;
        end
        tests++;
        if (!hit || outstanding !== 6'd2) begin
            failed++;
            $display("FAIL abort_setup: reached=%b out=%0d, expected 1 and 2", hit, outstanding);
        end
        last = solver_start;
        abort = 1;
        @(negedge clock);
        abort = 0;
        solver_done = last;
        tests++;
        if (busy !== 1'b0 || outstanding !== 6'd0 || solver_start !== 3'b000 || frame_done !== 1'b0) begin
            failed++;
            $display("FAIL abort_idle: busy=%b out=%0d start=%b fd=%b, expected 0 0 000 0",
                     busy, outstanding, solver_start, frame_done);
        end
        @(negedge clock);
        solver_done = '0;
        repeat (4) begin
            @(negedge clock);
            if (frame_done) fd++;
        end
        tests++;
        if (fd != 0 || outstanding !== 6'd0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL abort_after: frame_done=%0d out=%0d busy=%b, expected 0 0 0", fd, outstanding, busy);
        end
    endtask

    task automatic test_single_solver();
        logic [0:0] prev = '0;
        int n = 0, fd = 0;
        do_reset();
        ready2 = 1'b1;
        start2 = 1; @(negedge clock); start2 = 0;
        for (int c = 0; c < 200 && fd == 0; c++) begin
            @(negedge clock);
            done2 = prev;
            prev = solver_start2;
            if (frame_done2) fd++;
            if (solver_start2 !== 1'b0) begin
                tests++;
                if (job_addr2 !== 19'(n) || job_x2 !== 10'(n % 5) || job_y2 !== 9'(n / 5)) begin
                    failed++;
                    $display("FAIL one_start%0d: addr=%0d x=%0d y=%0d, expected %0d %0d %0d",
                             n, job_addr2, job_x2, job_y2, n, n % 5, n / 5);
                end
                n++;
            end
        end
        done2 = '0;
        repeat (3) begin
            @(negedge clock);
            if (frame_done2) fd++;
        end
        tests++;
        if (n != 15 || fd != 1 || job_addr2 !== 19'd14 || job_x2 !== 10'd4 || job_y2 !== 9'd2 || busy2 !== 1'b0) begin
            failed++;
            $display("FAIL one_totals: starts=%0d fd=%0d addr=%0d x=%0d y=%0d busy=%b, expected 15 1 14 4 2 0",
                     n, fd, job_addr2, job_x2, job_y2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_round_robin();
        test_single_ready();
        test_start_held();
        test_abort();
        test_single_solver();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
